// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer.
// Picks a pseudo-random mole from a free-running LFSR, lights it on a one-hot LED bus,
// times it out, and scores hits, misses and wrong presses over ROUNDS moles.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      start request (rising edge used; ignored while a game is running)
//   hit_Index  key flags from the keyboard scanner, bit i = key i
//   mole_led   one-hot lit mole, or 0
//   score      correct hits (saturating)
//   miss       timed-out moles (saturating)
//   wrong      presses on unlit keys (saturating)
//   round_cnt  moles completed in the current game
//   busy       game in progress (SPAWN/SHOW/GAP)
//   game_over  game finished (OVER)
module mole_game_ctrl #(
  parameter int unsigned TICK_DIV = 50_000,
  parameter int unsigned MOLE_MS  = 1000,
  parameter int unsigned GAP_MS   = 300,
  parameter int unsigned ROUNDS   = 30,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] hit_Index,
  output logic [15:0] mole_led,
  output logic [7:0]  score,
  output logic [7:0]  miss,
  output logic [7:0]  wrong,
  output logic [7:0]  round_cnt,
  output logic        busy,
  output logic        game_over
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMax = (MOLE_MS > GAP_MS) ? MOLE_MS : GAP_MS;
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  typedef enum logic [2:0] {StIdle, StSpawn, StShow, StGap, StOver} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          start_prev_q;
  logic [15:0]   hit_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   mole_led_q, mole_led_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    miss_q, miss_d;
  logic [7:0]    wrong_q, wrong_d;
  logic [7:0]    round_q, round_d;

  logic          start_rise;
  logic [15:0]   hit_rise;
  logic          tick;
  logic [3:0]    cand;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    start_rise = start & ~start_prev_q;
    hit_rise   = hit_Index & ~hit_prev_q;
    tick       = (presc_q == PW'(TICK_DIV - 1));
    // x^16 + x^14 + x^13 + x^11 + 1, shifting every cycle regardless of state
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cand       = lfsr_q[3:0];

    state_d    = state_q;
    idx_d      = idx_q;
    mole_led_d = mole_led_q;
    score_d    = score_q;
    miss_d     = miss_q;
    wrong_d    = wrong_q;
    round_d    = round_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          score_d = '0;
          miss_d  = '0;
          wrong_d = '0;
          round_d = '0;
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        // Never repeat the previous mole; 4-bit add wraps 15 to 0
        idx_d      = (cand == idx_q) ? cand + 4'd1 : cand;
        mole_led_d = 16'd1 << idx_d;
        state_d    = StShow;
      end
      StShow: begin
        // A correct key wins over stray keys and over a same-cycle timeout
        if (hit_rise[idx_q]) begin
          score_d    = sat_inc(score_q);
          mole_led_d = '0;
          state_d    = StGap;
        end else if (|hit_rise) begin
          wrong_d = sat_inc(wrong_q);
        end else if (tick && (timer_q == TW'(MOLE_MS - 1))) begin
          miss_d     = sat_inc(miss_q);
          mole_led_d = '0;
          state_d    = StGap;
        end
      end
      StGap: begin
        if (|hit_rise) begin
          wrong_d = sat_inc(wrong_q);
        end
        if (tick && (timer_q == TW'(GAP_MS - 1))) begin
          round_d = round_q + 8'd1;
          state_d = (round_q == 8'(ROUNDS - 1)) ? StOver : StSpawn;
        end
      end
      default: state_d = StIdle;
    endcase

    // Prescaler and tick timer restart on every state entry
    if (state_d != state_q) begin
      presc_d = '0;
      timer_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      timer_d = tick ? timer_q + 1'b1 : timer_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      lfsr_q       <= SEED;
      start_prev_q <= 1'b0;
      hit_prev_q   <= '0;
      presc_q      <= '0;
      timer_q      <= '0;
      idx_q        <= '0;
      mole_led_q   <= '0;
      score_q      <= '0;
      miss_q       <= '0;
      wrong_q      <= '0;
      round_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= start;
      hit_prev_q   <= hit_Index;
      presc_q      <= presc_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      mole_led_q   <= mole_led_d;
      score_q      <= score_d;
      miss_q       <= miss_d;
      wrong_q      <= wrong_d;
      round_q      <= round_d;
    end
  end

  assign mole_led  = mole_led_q;
  assign score     = score_q;
  assign miss      = miss_q;
  assign wrong     = wrong_q;
  assign round_cnt = round_q;
  assign busy      = (state_q == StSpawn) || (state_q == StShow) || (state_q == StGap);
  assign game_over = (state_q == StOver);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with short timing parameters.
module tb_mole_game_ctrl;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned MoleMs  = 5;
  localparam int unsigned GapMs   = 2;
  localparam int unsigned Rounds  = 3;
  localparam logic [15:0] Seed    = 16'hACE1;
  localparam int ShowCyc  = MoleMs * TickDiv;
  localparam int RoundCyc = 1 + (MoleMs + GapMs) * TickDiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hit_Index = '0;
  logic [15:0] mole_led;
  logic [7:0]  score, miss, wrong, round_cnt;
  logic        busy, game_over;

  int errors = 0;
  int checks = 0;

  // Reference model: polynomial LFSR stepped once per clock, plus the "no repeat" rule
  logic [15:0] m_lfsr, m_lfsr_prev;
  logic [15:0] m_exp_led = '0;
  logic [15:0] last_led = '0;
  logic [3:0]  m_prev_idx = '0;
  int          spawns = 0;

  mole_game_ctrl #(
    .TICK_DIV(TickDiv),
    .MOLE_MS (MoleMs),
    .GAP_MS  (GapMs),
    .ROUNDS  (Rounds),
    .SEED    (Seed)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hit_Index(hit_Index),
    .mole_led (mole_led),
    .score    (score),
    .miss     (miss),
    .wrong    (wrong),
    .round_cnt(round_cnt),
    .busy     (busy),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    // taps at polynomial degrees 16, 14, 13, 11
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr      <= Seed;
      m_lfsr_prev <= Seed;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_next(m_lfsr);
    end
  end

  // Advance one clock and sample; a fresh mole gets its expected position from the model
  task automatic step();
    logic [3:0] c;
    @(posedge clk);
    #1;
    if (mole_led !== 16'h0 && last_led === 16'h0) begin
      c = m_lfsr_prev[3:0];
      if (c == m_prev_idx) c = c + 4'd1;
      m_prev_idx = c;
      m_exp_led  = 16'h1 << c;
      spawns++;
    end
    last_led = mole_led;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_mole(output bit found);
    for (int i = 0; i < 40; i++) begin
      if (mole_led !== 16'h0) break;
      step();
    end
    found = (mole_led !== 16'h0);
  endtask

  task automatic wait_over(output bit found);
    for (int i = 0; i < 150; i++) begin
      if (game_over === 1'b1) break;
      step();
    end
    found = (game_over === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    hit_Index = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m_prev_idx = '0;
    last_led = '0;
    step();
    checks++; if (mole_led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want 0", mole_led); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (miss !== 8'd0) begin errors++; $display("FAIL reset_miss: got %0d want 0", miss); end
    checks++; if (wrong !== 8'd0) begin errors++; $display("FAIL reset_wrong: got %0d want 0", wrong); end
    checks++; if (round_cnt !== 8'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", round_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b want 0", game_over); end
  endtask

  task automatic test_timeout_game();
    int t, lit, moles;
    logic [15:0] prev_led;
    repeat ($urandom_range(0, 17)) step();
    pulse_start();
    t = 0; lit = 0; moles = 0; prev_led = '0;
    while (game_over !== 1'b1 && t < 150) begin
      step();
      t++;
      if (mole_led !== 16'h0) begin
        if (lit == 0) begin
          moles++;
          checks++; if (!$onehot(mole_led)) begin errors++; $display("FAIL onehot: got %h want one-hot", mole_led); end
          checks++; if (mole_led !== m_exp_led) begin errors++; $display("FAIL mole_pos: got %h want %h", mole_led, m_exp_led); end
          if (moles > 1) begin
            checks++; if (mole_led === prev_led) begin errors++; $display("FAIL mole_repeat: got %h want != %h", mole_led, prev_led); end
          end
          prev_led = mole_led;
        end
        lit++;
      end else if (lit != 0) begin
        checks++; if (lit != ShowCyc) begin errors++; $display("FAIL show_len: got %0d want %0d", lit, ShowCyc); end
        lit = 0;
      end
    end
    checks++; if (t != int'(Rounds) * RoundCyc) begin errors++; $display("FAIL game_len: got %0d want %0d", t, int'(Rounds) * RoundCyc); end
    checks++; if (moles != int'(Rounds)) begin errors++; $display("FAIL mole_count: got %0d want %0d", moles, Rounds); end
    checks++; if (miss !== 8'(Rounds)) begin errors++; $display("FAIL to_miss: got %0d want %0d", miss, Rounds); end
    checks++; if (score !== 8'd0) begin errors++; $display("FAIL to_score: got %0d want 0", score); end
    checks++; if (wrong !== 8'd0) begin errors++; $display("FAIL to_wrong: got %0d want 0", wrong); end
    checks++; if (round_cnt !== 8'(Rounds)) begin errors++; $display("FAIL to_round: got %0d want %0d", round_cnt, Rounds); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL to_over: got %b want 1", game_over); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
  endtask

  task automatic test_correct_hit();
    bit found;
    pulse_start();
    checks++; if (score !== 8'd0 || miss !== 8'd0 || round_cnt !== 8'd0) begin
      errors++; $display("FAIL restart_clear: got s=%0d m=%0d r=%0d want 0/0/0", score, miss, round_cnt); end
    checks++; if (busy !== 1'b1 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart_state: got busy=%b over=%b want 1/0", busy, game_over); end
    wait_mole(found);
    checks++; if (!found) begin errors++; $display("FAIL hit_spawn: got no mole want mole"); end
    repeat ($urandom_range(3, 12)) step();
    hit_Index = mole_led;
    step();
    checks++; if (score !== 8'd1) begin errors++; $display("FAIL hit_score: got %0d want 1", score); end
    checks++; if (mole_led !== 16'h0) begin errors++; $display("FAIL hit_clear: got %h want 0", mole_led); end
    repeat (39) step();
    hit_Index = '0;
    checks++; if (score !== 8'd1 || wrong !== 8'd0) begin
      errors++; $display("FAIL hold_once: got s=%0d w=%0d want 1/0", score, wrong); end
    wait_over(found);
    checks++; if (!found) begin errors++; $display("FAIL hit_over: got no game_over want 1"); end
    checks++; if (score !== 8'd1 || miss !== 8'(Rounds - 1) || wrong !== 8'd0) begin
      errors++; $display("FAIL hit_final: got s=%0d m=%0d w=%0d want 1/%0d/0", score, miss, wrong, Rounds - 1); end
  endtask

  task automatic test_wrong_press();
    bit found;
    int k, j;
    pulse_start();
    wait_mole(found);
    checks++; if (!found) begin errors++; $display("FAIL wrong_spawn: got no mole want mole"); end
    repeat ($urandom_range(1, 8)) step();
    k = (int'(m_prev_idx) + int'($urandom_range(1, 15))) % 16;
    hit_Index = 16'h1 << k;
    step();
    checks++; if (wrong !== 8'd1 || score !== 8'd0) begin
      errors++; $display("FAIL wrong_count: got w=%0d s=%0d want 1/0", wrong, score); end
    checks++; if (mole_led !== m_exp_led) begin errors++; $display("FAIL wrong_lit: got %h want %h", mole_led, m_exp_led); end
    j = int'($urandom_range(0, 15));
    while (j == k || j == int'(m_prev_idx)) j = (j + 1) % 16;
    hit_Index = (16'h1 << k) | mole_led | (16'h1 << j);
    step();
    checks++; if (score !== 8'd1 || wrong !== 8'd1) begin
      errors++; $display("FAIL combo_press: got s=%0d w=%0d want 1/1", score, wrong); end
    checks++; if (mole_led !== 16'h0) begin errors++; $display("FAIL combo_clear: got %h want 0", mole_led); end
    hit_Index = '0;
    wait_over(found);
    checks++; if (!found || score !== 8'd1 || wrong !== 8'd1 || miss !== 8'(Rounds - 1)) begin
      errors++; $display("FAIL wrong_final: got s=%0d w=%0d m=%0d want 1/1/%0d", score, wrong, miss, Rounds - 1); end
  endtask

  task automatic test_hit_at_deadline();
    bit found;
    pulse_start();
    wait_mole(found);
    checks++; if (!found) begin errors++; $display("FAIL dl_spawn: got no mole want mole"); end
    repeat (ShowCyc - 1) step();
    checks++; if (mole_led !== m_exp_led) begin errors++; $display("FAIL dl_lit: got %h want %h", mole_led, m_exp_led); end
    hit_Index = mole_led;
    step();
    checks++; if (score !== 8'd1 || miss !== 8'd0) begin
      errors++; $display("FAIL dl_hit: got s=%0d m=%0d want 1/0", score, miss); end
    checks++; if (mole_led !== 16'h0) begin errors++; $display("FAIL dl_clear: got %h want 0", mole_led); end
    hit_Index = '0;
    wait_over(found);
    checks++; if (!found || score !== 8'd1 || miss !== 8'(Rounds - 1)) begin
      errors++; $display("FAIL dl_final: got s=%0d m=%0d want 1/%0d", score, miss, Rounds - 1); end
  endtask

  task automatic test_restart_reset();
    bit found;
    int cnt;
    pulse_start();
    wait_mole(found);
    checks++; if (!found) begin errors++; $display("FAIL rs_spawn: got no mole want mole"); end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++; if (mole_led !== m_exp_led || busy !== 1'b1) begin
      errors++; $display("FAIL start_in_show: got %h busy=%b want %h busy=1", mole_led, busy, m_exp_led); end
    cnt = 0;
    while (mole_led !== 16'h0 && cnt < 40) begin
      cnt++;
      step();
    end
    checks++; if (cnt != ShowCyc - 3) begin errors++; $display("FAIL show_after_start: got %0d want %0d", cnt, ShowCyc - 3); end
    wait_mole(found);
    checks++; if (!found) begin errors++; $display("FAIL rs_spawn2: got no mole want mole"); end
    repeat ($urandom_range(1, 10)) step();
    #3;
    rst = 1'b0;
    #1;
    checks++; if (mole_led !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h busy=%b want 0 busy=0", mole_led, busy); end
    checks++; if (miss !== 8'd0 || round_cnt !== 8'd0 || score !== 8'd0) begin
      errors++; $display("FAIL reset_counts: got m=%0d r=%0d s=%0d want 0", miss, round_cnt, score); end
    m_prev_idx = '0;
    last_led = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step();
    checks++; if (mole_led !== 16'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got %h busy=%b want 0 busy=0", mole_led, busy); end
    pulse_start();
    wait_mole(found);
    checks++; if (!found || mole_led !== m_exp_led) begin
      errors++; $display("FAIL resume_pos: got %h want %h", mole_led, m_exp_led); end
  endtask

  initial begin
    test_reset();
    test_timeout_game();
    test_correct_hit();
    test_wrong_press();
    test_hit_at_deadline();
    test_restart_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1);
  end

endmodule
